pot_scan_sequencer: RTL and testbench

POT_SCAN_SEQUENCER -- requirements
Module: pot_scan_sequencer

---
 rtl/pot_scan_sequencer.sv | 145 ++++++++++++++
 tb/tb_pot_scan_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_scan_sequencer.sv
// Paddle pot scan sequencer: emulates discharge/charge timing per enabled channel and latches readings.
// Latency: DIS_TICKS + target + 1 ce ticks plus 2 clk per channel; scans auto-start every SCAN_DIV ce ticks.
// Backpressure: none; start while busy is dropped, mask is snapshotted at scan start. Option: POT_SCAN_FILTER_EN.
module pot_scan_sequencer #(
    parameter int SCAN_DIV  = 512,
    parameter int DIS_TICKS = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic            start,
    input  logic [3:0]      mask,
    input  logic [3:0]      is_paddle,
    input  logic [3:0][7:0] pd_in,
    output logic [3:0][7:0] pot_val,
    output logic [3:0]      pot_valid,
    output logic            busy,
    output logic            scan_done,
    output logic [1:0]      ch
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DIS_TICKS > 1) ? $clog2(DIS_TICKS) : 1;

    typedef enum logic [2:0] {IDLE, DISCHARGE, CHARGE, LATCH, NEXT} state_t;

    state_t          state;
    logic [PW-1:0]   period_cnt;
    logic [DW-1:0]   dis_cnt;
    logic [7:0]      chg_cnt;
    logic [7:0]      target;
    logic [7:0]      result;
    logic [3:0]      scan_mask;
    logic [7:0]      latch_val;
    logic            nxt_found;
    logic [1:0]      nxt_ch;
    logic [1:0]      first_ch;

    always_comb begin
        first_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) first_ch = 2'(i);
        end
    end

    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = ch;
        for (int i = 3; i >= 0; i--) begin
            if (scan_mask[i] && (i > int'(ch))) begin
                nxt_found = 1'b1;
                nxt_ch    = 2'(i);
            end
        end
    end

`ifdef POT_SCAN_FILTER_EN
    // Rounded average of the previous reading and the new one; first reading passes straight through.
    logic [8:0] filt_sum;
    assign filt_sum  = {1'b0, pot_val[ch]} + {1'b0, result} + 9'd1;
    assign latch_val = pot_valid[ch] ? filt_sum[8:1] : result;
`else
    assign latch_val = result;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            period_cnt <= '0;
            dis_cnt    <= '0;
            chg_cnt    <= '0;
            target     <= 8'hFF;
            result     <= '0;
            scan_mask  <= '0;
            pot_val    <= '1;
            pot_valid  <= '0;
            busy       <= 1'b0;
            scan_done  <= 1'b0;
            ch         <= 2'd0;
        end else begin
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || (ce && period_cnt == PW'(SCAN_DIV - 1))) begin
                        period_cnt <= '0;
                        scan_mask  <= mask;
                        busy       <= 1'b1;
                        dis_cnt    <= '0;
                        if (mask != 4'b0000) begin
                            ch    <= first_ch;
                            state <= DISCHARGE;
                        end else begin
                            state <= NEXT;
                        end
                    end else if (ce) begin
                        period_cnt <= period_cnt + 1'b1;
                    end
                end
                DISCHARGE: begin
                    if (ce) begin
                        if (dis_cnt == DW'(DIS_TICKS - 1)) begin
                            // Target is frozen here so later pd_in changes cannot disturb this channel.
                            target  <= is_paddle[ch] ? pd_in[ch] : 8'hFF;
                            chg_cnt <= '0;
                            state   <= CHARGE;
                        end else begin
                            dis_cnt <= dis_cnt + 1'b1;
                        end
                    end
                end
                CHARGE: begin
                    if (ce) begin
                        if (chg_cnt == target) begin
                            result <= chg_cnt;
                            state  <= LATCH;
                        end else begin
                            chg_cnt <= chg_cnt + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    pot_val[ch]   <= latch_val;
                    pot_valid[ch] <= 1'b1;
                    state         <= NEXT;
                end
                NEXT: begin
                    if (nxt_found) begin
                        ch      <= nxt_ch;
                        dis_cnt <= '0;
                        state   <= DISCHARGE;
                    end else begin
                        scan_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pot_scan_sequencer.sv
// Bench for pot_scan_sequencer: vector table, directed timing sequences and randomized scans vs a scan-level model.
module tb_pot_scan_sequencer;

    logic            clk = 1'b0;
    logic            reset, ce, start;
    logic [3:0]      mask, is_paddle;
    logic [3:0][7:0] pd_in;
    logic [3:0][7:0] pot_val;
    logic [3:0]      pot_valid;
    logic            busy, scan_done;
    logic [1:0]      ch;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic last_ce  = 1'b0;

    logic [7:0] mv [4];
    logic [3:0] mvalid;

`ifdef POT_SCAN_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic [3:0]  m;
        logic [3:0]  ip;
        logic [31:0] pd;
        logic [31:0] exp_val;
        logic [3:0]  exp_valid;
    } vec_t;

    vec_t vecs [5];

    pot_scan_sequencer #(.SCAN_DIV(512), .DIS_TICKS(16)) dut (
        .clk(clk), .reset(reset), .ce(ce), .start(start), .mask(mask),
        .is_paddle(is_paddle), .pd_in(pd_in), .pot_val(pot_val),
        .pot_valid(pot_valid), .busy(busy), .scan_done(scan_done), .ch(ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ce is high on every 4th clock edge.
    task automatic clk1();
        ce = (cyc % 4 == 0);
        last_ce = ce;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk1();
        reset = 1'b0;
    endtask

    function automatic logic [7:0] model_latch(input logic [7:0] old, input logic was_valid,
                                               input logic [7:0] res);
        model_latch = res;
        if (FILT && was_valid) model_latch = 8'((int'(old) + int'(res) + 1) / 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mv[i] = 8'hFF;
        mvalid = 4'b0000;
    endtask

    task automatic model_scan(input logic [3:0] m, input logic [3:0] ip, input logic [31:0] pd,
                              output logic [7:0] exp_order, output int exp_n);
        logic [7:0] t;
        exp_order = '0;
        exp_n = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                t = ip[i] ? pd[8*i +: 8] : 8'hFF;
                mv[i] = model_latch(mv[i], mvalid[i], t);
                mvalid[i] = 1'b1;
                exp_order[2*exp_n +: 2] = 2'(i);
                exp_n++;
            end
        end
    endtask

    // Runs one started scan to completion; records channel visit order and scan_done pulses.
    task automatic do_scan(input logic [3:0] m, input logic [3:0] ip, input logic [31:0] pd,
                           input logic [3:0] m_after, input bit rnd_start,
                           output int n_done, output logic [7:0] order, output int n_order);
        logic [1:0] prev_ch, last_push;
        logic       prev_busy;
        bit         done;
        n_done = 0; order = '0; n_order = 0; done = 0;
        prev_busy = 1'b0; prev_ch = 2'd0; last_push = 2'd0;
        mask = m; is_paddle = ip; pd_in = pd;
        start = 1'b1;
        clk1();
        start = 1'b0;
        mask = m_after;
        for (int k = 0; k < 8000 && !done; k++) begin
            if (busy && prev_busy && ch == prev_ch && (n_order == 0 || ch != last_push)) begin
                if (n_order < 4) order[2*n_order +: 2] = ch;
                n_order++;
                last_push = ch;
            end
            prev_busy = busy;
            prev_ch = ch;
            if (rnd_start && busy && $urandom_range(0, 39) == 0) start = 1'b1;
            clk1();
            start = 1'b0;
            if (scan_done) begin
                n_done++;
                done = 1;
            end
        end
        for (int k = 0; k < 6; k++) begin
            clk1();
            if (scan_done) n_done++;
        end
    endtask

    initial begin
        int         n_done, n_order, exp_n, n;
        logic [7:0] order, exp_order;
        logic [3:0] rm, rip;
        logic [31:0] rpd;

        reset = 1'b0; ce = 1'b0; start = 1'b0;
        mask = '0; is_paddle = '0; pd_in = '0;
        clk1();

        do_reset();
        chk("reset_pot_val", pot_val, 32'hFFFF_FFFF);
        chk("reset_pot_valid", pot_valid, 4'b0000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_scan_done", scan_done, 1'b0);
        chk("reset_ch", ch, 2'd0);

        vecs[0] = '{1'b1, 4'b0001, 4'b0001, 32'h0000_0040, 32'hFFFF_FF40, 4'b0001};
        vecs[1] = '{1'b1, 4'b1010, 4'b0010, 32'h1122_0033, 32'hFFFF_00FF, 4'b1010};
        vecs[2] = '{1'b0, 4'b0100, 4'b0100, 32'h0005_0000, 32'hFF05_00FF, 4'b1110};
        vecs[3] = '{1'b0, 4'b0000, 4'b1111, 32'h0000_0000, 32'hFF05_00FF, 4'b1110};
        vecs[4] = '{1'b1, 4'b1111, 4'b1001, 32'h1077_3302, 32'h10FF_FF02, 4'b1111};

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].rst) begin
                do_reset();
                model_reset();
            end
            model_scan(vecs[v].m, vecs[v].ip, vecs[v].pd, exp_order, exp_n);
            do_scan(vecs[v].m, vecs[v].ip, vecs[v].pd, vecs[v].m, 1'b0, n_done, order, n_order);
            chk($sformatf("vec%0d_done_count", v), n_done, 1);
            chk($sformatf("vec%0d_ch_count", v), n_order, exp_n);
            chk($sformatf("vec%0d_ch_order", v), order, exp_order);
            chk($sformatf("vec%0d_pot_val", v), pot_val, vecs[v].exp_val);
            chk($sformatf("vec%0d_pot_valid", v), pot_valid, vecs[v].exp_valid);
        end

        // Per-channel latency: 16 discharge + 0x40+1 charge ce ticks, then LATCH and NEXT clocks.
        do_reset();
        mask = 4'b0001; is_paddle = 4'b0001; pd_in = 32'h0000_0040;
        start = 1'b1;
        clk1();
        start = 1'b0;
        n = 0;
        for (int k = 0; k < 2000; k++) begin
            clk1();
            if (pot_valid[0]) break;
            n += int'(last_ce);
        end
        chk("latency_ce_ticks", n, 81);
        chk("latency_pot_val0", pot_val[0], 8'h40);
        chk("latency_busy_at_latch", busy, 1'b1);
        clk1();
        chk("latency_done_pulse", scan_done, 1'b1);
        chk("latency_idle_after", busy, 1'b0);
        clk1();
        chk("latency_done_single", scan_done, 1'b0);

        // Empty mask: busy one clk, scan_done the next.
        mask = 4'b0000;
        start = 1'b1;
        clk1();
        start = 1'b0;
        chk("empty_busy", busy, 1'b1);
        chk("empty_done_early", scan_done, 1'b0);
        clk1();
        chk("empty_busy_drop", busy, 1'b0);
        chk("empty_done", scan_done, 1'b1);
        chk("empty_pot_val", pot_val, 32'hFFFF_FF40);

        // Automatic scan timing and start-while-busy rejection.
        do_reset();
        mask = 4'b0001; is_paddle = 4'b0001; pd_in = 32'h0000_0010;
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            clk1();
            n += int'(last_ce);
            if (busy) break;
        end
        chk("auto_start_ce_ticks", n, 512);
        n_done = 0;
        for (int k = 0; k < 400; k++) begin
            start = (k == 20 || k == 21);
            clk1();
            start = 1'b0;
            if (scan_done) begin
                n_done++;
                break;
            end
        end
        chk("auto_scan_done", n_done, 1);
        n = 0;
        for (int k = 0; k < 3000; k++) begin
            clk1();
            if (scan_done) n_done++;
            n += int'(last_ce);
            if (busy) break;
        end
        chk("auto_restart_ce_ticks", n, 512);
        chk("auto_no_extra_scan", n_done, 1);

        // Reset during CHARGE on channel 2.
        do_reset();
        mask = 4'b0100; is_paddle = 4'b0100; pd_in = 32'h0080_0000;
        start = 1'b1;
        clk1();
        start = 1'b0;
        for (int k = 0; k < 100; k++) clk1();
        chk("charge_busy_before_reset", busy, 1'b1);
        chk("charge_ch_before_reset", ch, 2'd2);
        do_reset();
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_ch", ch, 2'd0);
        chk("midreset_pot_val", pot_val, 32'hFFFF_FFFF);
        chk("midreset_pot_valid", pot_valid, 4'b0000);
        n_done = 0;
        for (int k = 0; k < 600; k++) begin
            clk1();
            if (scan_done) n_done++;
        end
        chk("midreset_no_done", n_done, 0);
        chk("midreset_no_write", pot_valid, 4'b0000);

`ifdef POT_SCAN_FILTER_EN
        do_reset();
        do_scan(4'b0001, 4'b0001, 32'h0000_0040, 4'b0001, 1'b0, n_done, order, n_order);
        chk("filter_first", pot_val[0], 8'h40);
        do_scan(4'b0001, 4'b0001, 32'h0000_00C1, 4'b0001, 1'b0, n_done, order, n_order);
        chk("filter_second", pot_val[0], 8'h81);
`endif

        // Randomized scans against the scan-level model.
        do_reset();
        model_reset();
        for (int r = 0; r < 12; r++) begin
            rm  = 4'($urandom);
            rip = 4'($urandom);
            rpd = '0;
            for (int b = 0; b < 4; b++) rpd[8*b +: 8] = 8'($urandom_range(0, 60));
            model_scan(rm, rip, rpd, exp_order, exp_n);
            do_scan(rm, rip, rpd, 4'($urandom), 1'b1, n_done, order, n_order);
            chk($sformatf("rnd%0d_done_count", r), n_done, 1);
            chk($sformatf("rnd%0d_ch_order", r), {n_order[7:0], order}, {exp_n[7:0], exp_order});
            chk($sformatf("rnd%0d_pot_val", r), pot_val, {mv[3], mv[2], mv[1], mv[0]});
            chk($sformatf("rnd%0d_pot_valid", r), pot_valid, mvalid);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
